// File: rtl/jtcps1_obj_pkg.sv
// jtcps1_obj_pkg: shared object-entry layout, attribute fields and scanner states.
package jtcps1_obj_pkg;
  localparam logic [1:0] W_X    = 2'd0;
  localparam logic [1:0] W_Y    = 2'd1;
  localparam logic [1:0] W_CODE = 2'd2;
  localparam logic [1:0] W_ATTR = 2'd3;
  localparam int A_PAL_LSB = 0;
  localparam int A_HFLIP   = 5;
  localparam int A_VFLIP   = 6;
  localparam int A_N_LSB   = 8;
  localparam int A_M_LSB   = 12;
  localparam logic [7:0] END_MARK = 8'hFF;
  typedef enum logic [2:0] {S_IDLE, S_READ, S_CHECK, S_EMIT, S_NEXT, S_DONE} state_t;
  // Tile code for column k of a row; hflip walks the columns right to left.
  function automatic logic [15:0] tile_code(input logic [15:0] code, input logic [3:0] row,
                                            input logic [3:0] n, input logic [3:0] k, input logic hflip);
    logic [3:0] col;
    col = hflip ? n - k : k;
    return code + {8'd0, row, 4'd0} + {12'd0, col};
  endfunction
endpackage

// File: rtl/jtcps1_obj_rowcalc.sv
// jtcps1_obj_rowcalc: vertical distance, tile row and in-tile pixel row for one object.
module jtcps1_obj_rowcalc
  import jtcps1_obj_pkg::*;
(
  input  logic [8:0] i_vrender,
  input  logic [8:0] i_y,
  input  logic [3:0] i_tile_m,
  input  logic       i_vflip,
  output logic       o_match,
  output logic [3:0] o_row,
  output logic [3:0] o_vsub
);
  logic [8:0] w_dy;
  always_comb begin
    w_dy    = i_vrender - i_y;
    o_match = w_dy[8:4] <= {1'b0, i_tile_m};
    o_row   = i_vflip ? i_tile_m - w_dy[7:4] : w_dy[7:4];
    o_vsub  = i_vflip ? ~w_dy[3:0] : w_dy[3:0];
  end
endmodule

// File: rtl/jtcps1_obj_scan_tx.sv
// jtcps1_obj_scan_tx: per-line object table scan issuing one draw request per tile column.
// Define JTCPS1_OBJ_LIMIT_EN to cap accepted requests per line at MAXTILES.
module jtcps1_obj_scan_tx
  import jtcps1_obj_pkg::*;
#(
  parameter int MAXOBJ   = 256,
  parameter int MAXTILES = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [8:0]  vrender,
  output logic [9:0]  tbl_addr,
  input  logic [15:0] tbl_data,
  output logic        dr_valid,
  input  logic        dr_ready,
  output logic [15:0] dr_code,
  output logic [8:0]  dr_hpos,
  output logic [3:0]  dr_vsub,
  output logic [4:0]  dr_pal,
  output logic        dr_hflip,
  output logic        busy,
  output logic        done,
  output logic        overflow
);
  state_t      r_st;
  logic [8:0]  r_vr, r_x, r_y;
  logic [15:0] r_code;
  logic [15:8] r_ahi;
  logic [6:0]  r_alo;
  logic [7:0]  r_idx;
  logic [2:0]  r_cnt;
  logic [3:0]  r_k, r_row;
  logic        r_valid;
  logic        w_match, w_hf, w_acc, w_last, w_cap;
  logic [3:0]  w_row, w_vsub, w_n, w_k1;
  assign w_n      = r_ahi[A_N_LSB +: 4];
  assign w_hf     = r_alo[A_HFLIP];
  assign w_k1     = r_k + 4'd1;
  assign w_acc    = r_valid & dr_ready;
  assign w_last   = r_idx == 8'(MAXOBJ - 1);
  // A restart pulse withdraws any pending request in the same cycle.
  assign dr_valid = r_valid & ~start;
  jtcps1_obj_rowcalc u_rowcalc (
    .i_vrender (r_vr),
    .i_y       (r_y),
    .i_tile_m  (r_ahi[A_M_LSB +: 4]),
    .i_vflip   (r_alo[A_VFLIP]),
    .o_match   (w_match),
    .o_row     (w_row),
    .o_vsub    (w_vsub)
  );
`ifdef JTCPS1_OBJ_LIMIT_EN
  localparam int ACW = $clog2(MAXTILES + 1);
  logic [ACW-1:0] r_acc;
  assign w_cap = w_acc && r_st == S_EMIT && r_acc == ACW'(MAXTILES - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      overflow <= 1'b0;
    end else if (start) begin
      r_acc    <= '0;
      overflow <= 1'b0;
    end else if (r_st == S_EMIT && w_acc) begin
      r_acc    <= r_acc + 1'b1;
      overflow <= overflow | w_cap;
    end
  end
`else
  // Uncapped build: MAXTILES only shapes the interface.
  assign w_cap    = 1'b0;
  assign overflow = MAXTILES < 0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st     <= S_IDLE;
      tbl_addr <= '0;
      r_vr     <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_code   <= '0;
      r_ahi    <= '0;
      r_alo    <= '0;
      r_idx    <= '0;
      r_cnt    <= '0;
      r_k      <= '0;
      r_row    <= '0;
      r_valid  <= 1'b0;
      dr_code  <= '0;
      dr_hpos  <= '0;
      dr_vsub  <= '0;
      dr_pal   <= '0;
      dr_hflip <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else if (start) begin
      r_st     <= S_READ;
      r_vr     <= vrender;
      r_idx    <= '0;
      r_cnt    <= '0;
      tbl_addr <= {8'd0, W_X};
      r_valid  <= 1'b0;
      busy     <= 1'b1;
      done     <= 1'b0;
    end else begin
      case (r_st)
        S_READ: begin
          // Word n is addressed at count n and captured at count n+1.
          r_cnt <= r_cnt + 3'd1;
          if (r_cnt < 3'd3) tbl_addr[1:0] <= tbl_addr[1:0] + 2'd1;
          if (r_cnt != 3'd0)
            case (2'(r_cnt - 3'd1))
              W_X:    r_x <= tbl_data[8:0];
              W_Y:    r_y <= tbl_data[8:0];
              W_CODE: r_code <= tbl_data;
              W_ATTR: {r_ahi, r_alo} <= {tbl_data[15:8], tbl_data[6:0]};
            endcase
          if (r_cnt == 3'd4) r_st <= S_CHECK;
        end
        S_CHECK: begin
          if (r_ahi == END_MARK) begin
            done <= 1'b1;
            busy <= 1'b0;
            r_st <= S_DONE;
          end else if (!w_match) begin
            r_st <= S_NEXT;
          end else begin
            r_row    <= w_row;
            r_k      <= '0;
            r_valid  <= 1'b1;
            dr_code  <= tile_code(r_code, w_row, w_n, 4'd0, w_hf);
            dr_hpos  <= r_x;
            dr_vsub  <= w_vsub;
            dr_pal   <= r_alo[A_PAL_LSB +: 5];
            dr_hflip <= w_hf;
            r_st     <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (w_cap) begin
            r_valid <= 1'b0;
            done    <= 1'b1;
            busy    <= 1'b0;
            r_st    <= S_DONE;
          end else if (w_acc && r_k == w_n) begin
            r_valid <= 1'b0;
            r_st    <= S_NEXT;
          end else if (w_acc) begin
            r_k     <= w_k1;
            dr_code <= tile_code(r_code, r_row, w_n, w_k1, w_hf);
            dr_hpos <= dr_hpos + 9'd16;
          end
        end
        S_NEXT: begin
          if (w_last) begin
            done <= 1'b1;
            busy <= 1'b0;
            r_st <= S_DONE;
          end else begin
            r_idx    <= r_idx + 8'd1;
            tbl_addr <= {r_idx + 8'd1, W_X};
            r_cnt    <= '0;
            r_st     <= S_READ;
          end
        end
        S_DONE: begin
          done <= 1'b0;
          r_st <= S_IDLE;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_jtcps1_obj_scan_tx.sv
// tb_jtcps1_obj_scan_tx: directed scans checked against a queue-based line model.
module tb_jtcps1_obj_scan_tx;
  localparam int MAXT = 4;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, dr_ready = 1'b1;
  logic [8:0]  vrender = '0;
  logic [15:0] tbl_data;
  logic [9:0]  tbl_addr;
  logic        dr_valid, dr_hflip, busy, done, overflow;
  logic [15:0] dr_code;
  logic [8:0]  dr_hpos;
  logic [3:0]  dr_vsub;
  logic [4:0]  dr_pal;
  logic [15:0] mem [0:1023];
  int vecs = 0, errs = 0;
  logic [34:0] expq [$];
  logic        exp_ovf = 1'b0;
  logic [34:0] cur, pv_pay;
  logic        pv_hold = 1'b0;
  int          stall = 0;
  logic        rdy_def = 1'b1;
  int          lat;

  jtcps1_obj_scan_tx #(.MAXOBJ(256), .MAXTILES(MAXT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .vrender(vrender), .tbl_addr(tbl_addr),
    .tbl_data(tbl_data), .dr_valid(dr_valid), .dr_ready(dr_ready), .dr_code(dr_code),
    .dr_hpos(dr_hpos), .dr_vsub(dr_vsub), .dr_pal(dr_pal), .dr_hflip(dr_hflip),
    .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) tbl_data <= mem[tbl_addr];
  always @(posedge clk) begin
    #1;
    if (stall > 0) begin dr_ready = 1'b0; stall--; end
    else dr_ready = rdy_def;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Expected requests of one line, straight from the entry rules.
  task automatic build(input logic [8:0] vr);
    int x, y, code, attr, n, m, dy, row, vsub, col, hf;
    expq.delete();
    exp_ovf = 1'b0;
    for (int i = 0; i < 256; i++) begin
      attr = int'(mem[4*i+3]);
      if (attr / 256 == 255) break;
      x = int'(mem[4*i]) % 512; y = int'(mem[4*i+1]) % 512; code = int'(mem[4*i+2]);
      n = (attr / 256) % 16; m = attr / 4096; hf = (attr / 32) % 2;
      dy = (int'(vr) - y + 512) % 512; row = dy / 16; vsub = dy % 16;
      if (row <= m) begin
        if ((attr / 64) % 2 == 1) begin vsub = 15 - vsub; row = m - row; end
        for (int k = 0; k <= n; k++) begin
          col = (hf == 1) ? n - k : k;
          expq.push_back({16'((code + row*16 + col) % 65536), 9'((x + 16*k) % 512), 4'(vsub), 5'(attr % 32), 1'(hf)});
        end
      end
    end
`ifdef JTCPS1_OBJ_LIMIT_EN
    if (expq.size() >= MAXT) begin
      exp_ovf = 1'b1;
      while (expq.size() > MAXT) void'(expq.pop_back());
    end
`endif
  endtask

  always @(negedge clk) if (rst_n) begin
    cur = {dr_code, dr_hpos, dr_vsub, dr_pal, dr_hflip};
    if (pv_hold && !start) begin
      chk("hold_valid", 64'(dr_valid), 64'(1'b1));
      chk("hold_payload", 64'(cur), 64'(pv_pay));
    end
    if (dr_valid && dr_ready) begin
      if (expq.size() == 0) begin
        vecs++; errs++;
        $display("FAIL extra_req: got %0h expected none", cur);
      end else chk("req", 64'(cur), 64'(expq.pop_front()));
    end
    if (done) begin
      chk("done_drained", 64'(expq.size()), 64'(0));
      chk("done_busy", 64'(busy), 64'(1'b0));
      chk("done_ovf", 64'(overflow), 64'(exp_ovf));
    end
    pv_hold = dr_valid && !dr_ready;
    pv_pay  = cur;
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask
  task automatic go(input logic [8:0] vr);
    vrender = vr; start = 1'b1; tick(); start = 1'b0;
  endtask
  task automatic wait_done(input int bound, output int n);
    n = 0;
    forever begin
      @(posedge clk); n++;
      @(negedge clk);
      if (done) break;
      if (n >= bound) begin vecs++; errs++; $display("FAIL done_timeout: got none expected done"); break; end
    end
    tick();
    chk("done_pulse", 64'(done), 64'(1'b0));
  endtask
  task automatic wait_valid(input int bound);
    int n;
    n = 0;
    while (!dr_valid && n < bound) begin @(negedge clk); n++; end
    chk("valid_seen", 64'(dr_valid), 64'(1'b1));
  endtask
  task automatic set_obj(input int i, input logic [8:0] x, input logic [8:0] y, input logic [15:0] code,
                         input logic [3:0] n, input logic [3:0] m, input logic vf, input logic hf, input logic [4:0] pal);
    mem[4*i] = {7'd0, x}; mem[4*i+1] = {7'd0, y}; mem[4*i+2] = code;
    mem[4*i+3] = {m, n, 1'b0, vf, hf, pal};
  endtask
  task automatic end_at(input int i);
    mem[4*i+3] = 16'hFF00;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = (i % 4 == 3) ? 16'hFF00 : 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outs", 64'({dr_valid, busy, done, overflow, tbl_addr, dr_code, dr_hpos, dr_vsub, dr_pal, dr_hflip}), 64'(0));
    rst_n = 1'b1;
    tick();
    // single object
    set_obj(0, 9'h040, 9'h020, 16'h1000, 4'd0, 4'd0, 1'b0, 1'b0, 5'd3); end_at(1);
    build(9'h025);
    chk("t1_len", 64'(expq.size()), 64'(1));
    chk("t1_req", 64'(expq[0]), 64'({16'h1000, 9'h040, 4'h5, 5'd3, 1'b0}));
    go(9'h025);
    chk("t1_busy", 64'(busy), 64'(1'b1));
    wait_done(200, lat);
    // wide, tall, hflip
    set_obj(0, 9'h040, 9'h020, 16'h1000, 4'd2, 4'd1, 1'b0, 1'b1, 5'h11);
    build(9'h035);
    chk("t2_req0", 64'(expq[0]), 64'({16'h1012, 9'h040, 4'h5, 5'h11, 1'b1}));
    chk("t2_req1", 64'(expq[1]), 64'({16'h1011, 9'h050, 4'h5, 5'h11, 1'b1}));
    chk("t2_req2", 64'(expq[2]), 64'({16'h1010, 9'h060, 4'h5, 5'h11, 1'b1}));
    go(9'h035);
    wait_done(200, lat);
    // vflip
    set_obj(0, 9'h040, 9'h020, 16'h1000, 4'd2, 4'd1, 1'b1, 1'b1, 5'h11);
    build(9'h035);
    chk("t3_req0", 64'(expq[0]), 64'({16'h1002, 9'h040, 4'hA, 5'h11, 1'b1}));
    chk("t3_req2", 64'(expq[2]), 64'({16'h1000, 9'h060, 4'hA, 5'h11, 1'b1}));
    go(9'h035);
    wait_done(200, lat);
    // backpressure: ready low while the first request waits
    set_obj(0, 9'h040, 9'h020, 16'h1000, 4'd2, 4'd1, 1'b0, 1'b1, 5'h11);
    build(9'h035);
    rdy_def = 1'b0;
    go(9'h035);
    wait_valid(50);
    stall = 7; rdy_def = 1'b1;
    wait_done(200, lat);
    // y and x wraparound, then end marker
    set_obj(0, 9'h1F8, 9'h1F8, 16'h2000, 4'd1, 4'd0, 1'b0, 1'b0, 5'h1F); end_at(1);
    build(9'h004);
    chk("t5_req0", 64'(expq[0]), 64'({16'h2000, 9'h1F8, 4'hC, 5'h1F, 1'b0}));
    chk("t5_req1", 64'(expq[1]), 64'({16'h2001, 9'h008, 4'hC, 5'h1F, 1'b0}));
    go(9'h004);
    wait_done(200, lat);
    // end marker at entry 0
    end_at(0);
    build(9'h010);
    chk("t6_len", 64'(expq.size()), 64'(0));
    go(9'h010);
    wait_done(200, lat);
    chk("t6_latency", 64'(lat), 64'(6));
    // mixed: miss, match, match
    set_obj(0, 9'h010, 9'h100, 16'h0300, 4'd0, 4'd1, 1'b0, 1'b0, 5'd1);
    set_obj(1, 9'h080, 9'h028, 16'h0400, 4'd1, 4'd0, 1'b0, 1'b0, 5'd2);
    set_obj(2, 9'h0C0, 9'h01C, 16'hFFFF, 4'd0, 4'd1, 1'b1, 1'b0, 5'd4); end_at(3);
    build(9'h030);
    chk("t7_len", 64'(expq.size()), 64'(3));
    go(9'h030);
    wait_done(300, lat);
    // restart during EMIT
    set_obj(0, 9'h040, 9'h020, 16'h1000, 4'd2, 4'd1, 1'b0, 1'b1, 5'h11); end_at(1);
    build(9'h035);
    rdy_def = 1'b0;
    go(9'h035);
    wait_valid(50);
    tick();
    build(9'h036);
    vrender = 9'h036; start = 1'b1;
    @(negedge clk);
    chk("abort_valid", 64'(dr_valid), 64'(1'b0));
    rdy_def = 1'b1;
    tick(); start = 1'b0;
    chk("restart_addr", 64'(tbl_addr), 64'(0));
    chk("restart_busy", 64'(busy), 64'(1'b1));
    wait_done(200, lat);
    // three width-2 objects against the request cap
    for (int i = 0; i < 3; i++) set_obj(i, 9'(32*i), 9'h050, 16'(16'h0100 * i), 4'd1, 4'd0, 1'b0, 1'b0, 5'd7);
    end_at(3);
    build(9'h052);
`ifdef JTCPS1_OBJ_LIMIT_EN
    chk("t9_len", 64'(expq.size()), 64'(4));
    chk("t9_ovf_model", 64'(exp_ovf), 64'(1'b1));
`else
    chk("t9_len", 64'(expq.size()), 64'(6));
`endif
    go(9'h052);
    wait_done(400, lat);
    chk("t9_ovf_held", 64'(overflow), 64'(exp_ovf));
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
